// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state types.
// Imported by the register-bank responder.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register storage: byte-strobed write port, async read port, flat image.
// Ports: clk, rst_n (sync clear), we/waddr/wdata/wstrb, raddr/rdata, image.
module axi4_lite_regfile #(
  parameter int DW = 32,
  parameter int NR = 16,
  parameter int IW = $clog2(NR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [DW/8-1:0]  wstrb,
  input  logic [IW-1:0]    raddr,
  output logic [DW-1:0]    rdata,
  output logic [NR*DW-1:0] image
);

  logic [NR-1:0][DW-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read is combinational so a same-edge write leaves the old value visible.
  assign rdata = mem[raddr];
  assign image = mem;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder over a bank of NUM_REGS registers; independent
// write (AW/W/B) and read (AR/R) FSMs; regs_q is the flat register image.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDRESS_WIDTH-1:0]     S_AWADDR,
  input  logic                         S_AWVALID,
  output logic                         S_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_WSTRB,
  input  logic                         S_WVALID,
  output logic                         S_WREADY,
  output logic [1:0]                   S_BRESP,
  output logic                         S_BVALID,
  input  logic                         S_BREADY,
  input  logic [ADDRESS_WIDTH-1:0]     S_ARADDR,
  input  logic                         S_ARVALID,
  output logic                         S_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_RDATA,
  output logic [1:0]                   S_RRESP,
  output logic                         S_RVALID,
  input  logic                         S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

  localparam int SW       = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IW       = $clog2(NUM_REGS);
  localparam logic [ADDRESS_WIDTH-1:0] LIMIT = ADDRESS_WIDTH'(NUM_REGS);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                     aw_held, w_held;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0]    w_data_q;
  logic [SW-1:0]            w_strb_q;
  logic [1:0]               bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  logic aw_rdy, w_rdy, bvalid, ar_rdy, rvalid;
  logic aw_hs, w_hs, ar_hs, commit;

  logic [ADDRESS_WIDTH-1:0] wr_addr, wr_word, rd_word;
  logic [DATA_WIDTH-1:0]    wr_data, rf_rdata;
  logic [SW-1:0]            wr_strb;
  logic                     wr_in, rd_in;
  logic [NUM_REGS*DATA_WIDTH-1:0] image;

  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID && S_WREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;

  // A latched beat takes priority; otherwise use the live channel.
  assign wr_addr = aw_held ? aw_addr_q : S_AWADDR;
  assign wr_data = w_held ? w_data_q : S_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_WSTRB;

  assign commit = (wr_state == W_IDLE)
               && (aw_held || aw_hs)
               && (w_held || w_hs);

  // Word index; bits above the index decide range.
  assign wr_word = wr_addr >> ADDR_LSB;
  assign rd_word = S_ARADDR >> ADDR_LSB;
  assign wr_in   = wr_word < LIMIT;
  assign rd_in   = rd_word < LIMIT;

  axi4_lite_regfile #(
    .DW (DATA_WIDTH),
    .NR (NUM_REGS),
    .IW (IW)
  ) u_regfile (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (commit && wr_in),
    .waddr (wr_word[IW-1:0]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (rd_word[IW-1:0]),
    .rdata (rf_rdata),
    .image (image)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: if (commit) wr_next = W_RESP;
      W_RESP: if (S_BREADY) wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE: if (ar_hs) rd_next = R_DATA;
      R_DATA: if (S_RREADY) rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    bvalid = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        aw_rdy = !aw_held;
        w_rdy  = !w_held;
      end
      W_RESP: bvalid = 1'b1;
    endcase
  end

  always_comb begin
    ar_rdy = 1'b0;
    rvalid = 1'b0;
    unique case (rd_state)
      R_IDLE: ar_rdy = 1'b1;
      R_DATA: rvalid = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= wr_in ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_WDATA;
        w_strb_q <= S_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in ? rf_rdata : '0;
      rresp_q <= rd_in ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Everything is forced low while reset is held.
  assign S_AWREADY = ARESETN && aw_rdy;
  assign S_WREADY  = ARESETN && w_rdy;
  assign S_BVALID  = ARESETN && bvalid;
  assign S_BRESP   = ARESETN ? bresp_q : 2'b00;
  assign S_ARREADY = ARESETN && ar_rdy;
  assign S_RVALID  = ARESETN && rvalid;
  assign S_RDATA   = ARESETN ? rdata_q : '0;
  assign S_RRESP   = ARESETN ? rresp_q : 2'b00;
  assign regs_q    = ARESETN ? image : '0;

endmodule
